// File: rtl/kgp_ctrl_fsm_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control path.
// Holds opcode/branch subcodes, mux selects and the sequencer state enum.
package kgp_ctrl_fsm_pkg;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BR    = 2'b11;

  // func[3:2] branch groups; 1x is register compare
  localparam logic [1:0] BRG_JMP  = 2'b00;
  localparam logic [1:0] BRG_FLAG = 2'b01;

  localparam logic [1:0] CND_Z  = 2'b00;
  localparam logic [1:0] CND_NZ = 2'b01;
  localparam logic [1:0] CND_S  = 2'b10;
  localparam logic [1:0] CND_NS = 2'b11;

  localparam logic [1:0] ALU_IMM_FN = 2'b10;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_OFF = 2'b01;
  localparam logic [1:0] PCSEL_RA  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BR     = 3'd6
  } state_t;

endpackage

// File: rtl/kgp_branch_eval.sv
// Combinational branch resolution: taken flag, PC target select and call marker.
// Kept free of state so the pipelined core can reuse it as-is.
module kgp_branch_eval
  import kgp_ctrl_fsm_pkg::*;
(
  input  logic [3:0] func,
  input  logic       zero_f,
  input  logic       sign_f,
  output logic       taken,
  output logic [1:0] pc_tgt,
  output logic       call
);

  always_comb begin
    taken  = 1'b0;
    pc_tgt = PCSEL_OFF;
    call   = 1'b0;
    case (func[3:2])
      BRG_JMP: begin
        taken = 1'b1;
        if (func[1]) begin
          pc_tgt = PCSEL_RA;
        end else begin
          call = func[0];
        end
      end
      BRG_FLAG: begin
        case (func[1:0])
          CND_Z:   taken = zero_f;
          CND_NZ:  taken = ~zero_f;
          CND_S:   taken = sign_f;
          CND_NS:  taken = ~sign_f;
          default: taken = 1'b0;
        endcase
      end
      // register compare: the ALU subtracts, func[0] selects equal / not-equal
      default: taken = zero_f ^ func[0];
    endcase
  end

endmodule

// File: rtl/kgp_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC core,
// with a memory-wait watchdog that raises a sticky err flag.
module kgp_ctrl_fsm
  import kgp_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RA_REG      = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] opcode,
  input  logic [3:0] func,
  input  logic       zero_f,
  input  logic       sign_f,
  input  logic       mem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       link,
  output logic       alu_src,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               wait_st;
  logic               timeout;
  logic               br_taken;
  logic [1:0]         br_tgt;
  logic               br_call;
  logic               alu_src_d;
  state_t             done_st;

  // The link register index is applied in the regfile address mux; only the link strobe leaves here.
  logic unused_ra;
  assign unused_ra = ^5'(RA_REG);

  kgp_branch_eval u_br (
    .func   (func),
    .zero_f (zero_f),
    .sign_f (sign_f),
    .taken  (br_taken),
    .pc_tgt (br_tgt),
    .call   (br_call)
  );

  assign wait_st   = (state == S_FETCH) || (state == S_MEM);
  assign timeout   = wait_st && !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign done_st   = run ? S_FETCH : S_IDLE;
  assign alu_src_d = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                     ((opcode == OP_ALU) && (func[2:1] == ALU_IMM_FN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      // counter restarts on every entry into a wait state, including timeout re-entry of FETCH
      if (wait_st && (state_nxt == state) && !timeout) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FETCH;
      end
      S_DECODE: state_nxt = (opcode == OP_BR) ? S_BR : S_EXEC;
      S_EXEC:   state_nxt = (opcode == OP_ALU) ? S_WB : S_MEM;
      S_MEM: begin
        if (mem_ready)    state_nxt = (opcode == OP_LOAD) ? S_WB : done_st;
        else if (timeout) state_nxt = S_FETCH;
      end
      S_WB:     state_nxt = done_st;
      S_BR:     state_nxt = done_st;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PCSEL_PC4;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    link     = 1'b0;
    alu_src  = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_EXEC: alu_src = alu_src_d;
      S_MEM: begin
        addr_sel = 1'b1;
        alu_src  = alu_src_d;
        mem_rd   = (opcode == OP_LOAD);
        mem_wr   = (opcode == OP_STORE);
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
      end
      S_BR: begin
        pc_we  = br_taken;
        pc_sel = br_taken ? br_tgt : PCSEL_PC4;
        if (br_call) begin
          rf_we  = 1'b1;
          link   = 1'b1;
          wb_sel = WB_LINK;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kgp_ctrl_fsm.sv
// Directed bench for kgp_ctrl_fsm: a per-cycle vector table plus hand sequences
// for reset, memory waits, watchdog timeout and run drop.
module tb_kgp_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [1:0] opcode;
  logic [3:0] func;
  logic       zero_f;
  logic       sign_f;
  logic       mem_ready;
  logic       ir_we, pc_we, mem_rd, mem_wr, addr_sel, rf_we, link, alu_src, busy, err;
  logic [1:0] pc_sel, wb_sel;
  logic [13:0] obus;

  int total = 0;
  int bad   = 0;

  kgp_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .opcode    (opcode),
    .func      (func),
    .zero_f    (zero_f),
    .sign_f    (sign_f),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .addr_sel  (addr_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .link      (link),
    .alu_src   (alu_src),
    .busy      (busy),
    .err       (err)
  );

  assign obus = {ir_we, pc_we, pc_sel, mem_rd, mem_wr, addr_sel, rf_we, wb_sel, link, alu_src, busy, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic [1:0]  op;
    logic [3:0]  fn;
    logic        z;
    logic        s;
    logic        rdy;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] o(input logic ir, input logic pc, input logic [1:0] ps,
                                    input logic rd, input logic wr, input logic as, input logic rf,
                                    input logic [1:0] wb, input logic lk, input logic src,
                                    input logic bsy, input logic er);
    return {ir, pc, ps, rd, wr, as, rf, wb, lk, src, bsy, er};
  endfunction

  function automatic vec_t v(input logic r, input logic [1:0] op, input logic [3:0] fn,
                             input logic z, input logic s, input logic rdy, input logic [13:0] e);
    vec_t t;
    t.run = r; t.op = op; t.fn = fn; t.z = z; t.s = s; t.rdy = rdy; t.exp = e;
    return t;
  endfunction

  task automatic drive(input logic r, input logic [1:0] op, input logic [3:0] fn,
                       input logic z, input logic s, input logic rdy);
    run = r; opcode = op; func = fn; zero_f = z; sign_f = s; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (ir pc psel rd wr as rf wb lk src busy err)", nm, act, exp);
    end
  endtask

  logic [13:0] z0;

  initial begin
    z0 = '0;
    rst_n = 1'b0;
    drive(0, 2'b00, 4'b0000, 0, 0, 0);
    chk("reset_state", obus, z0);
    tick();
    tick();
    rst_n = 1'b1;

    // cycle-by-cycle table: ALU ops, every branch flavour, then a store that parks in IDLE
    tbl.push_back(v(0, 2'b00, 4'b0000, 0, 0, 1, z0));
    tbl.push_back(v(1, 2'b00, 4'b0000, 0, 0, 1, z0));
    tbl.push_back(v(1, 2'b00, 4'b0000, 0, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,0,0,1,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0100, 0, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0100, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0100, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0)));
    tbl.push_back(v(1, 2'b00, 4'b0100, 0, 0, 1, o(0,0,2'b00,0,0,0,1,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1000, 1, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1000, 1, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1000, 1, 0, 1, o(0,1,2'b01,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1001, 1, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1001, 1, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b1001, 1, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0001, 0, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0001, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0001, 0, 0, 1, o(0,1,2'b01,0,0,0,1,2'b10,1,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0010, 0, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0010, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0010, 0, 0, 1, o(0,1,2'b10,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0110, 0, 1, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0110, 0, 1, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0110, 0, 1, 1, o(0,1,2'b01,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0101, 1, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0101, 1, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b11, 4'b0101, 1, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b10, 4'b0000, 0, 0, 1, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b10, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,0,1,0)));
    tbl.push_back(v(1, 2'b10, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0)));
    tbl.push_back(v(0, 2'b10, 4'b0000, 0, 0, 1, o(0,0,2'b00,0,1,1,0,2'b00,0,1,1,0)));
    tbl.push_back(v(0, 2'b10, 4'b0000, 0, 0, 1, z0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].run, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].s, tbl[i].rdy);
      chk($sformatf("vec%0d", i), obus, tbl[i].exp);
      tick();
    end

    // reset asserted while FETCH holds mem_rd
    drive(1, 2'b00, 4'b0000, 0, 0, 0);
    tick();
    drive(1, 2'b00, 4'b0000, 0, 0, 0);
    chk("fetch_wait", obus, o(0,0,2'b00,1,0,0,0,2'b00,0,0,1,0));
    rst_n = 1'b0;
    #1;
    chk("async_reset", obus, z0);
    drive(0, 2'b00, 4'b0000, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", obus, z0);

    // load with mem_ready arriving on the 4th MEM cycle
    drive(1, 2'b01, 4'b0000, 0, 0, 1);
    tick();
    chk("ld_fetch", obus, o(1,1,2'b00,1,0,0,0,2'b00,0,0,1,0));
    tick();
    tick();
    chk("ld_exec", obus, o(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0));
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'b01, 4'b0000, 0, 0, (k == 3));
      chk($sformatf("ld_mem%0d", k), obus, o(0,0,2'b00,1,0,1,0,2'b00,0,1,1,0));
      tick();
    end
    chk("ld_wb", obus, o(0,0,2'b00,0,0,0,1,2'b01,0,0,1,0));
    drive(1, 2'b01, 4'b0000, 0, 0, 1);
    tick();

    // mem_ready on the last allowed MEM cycle is still a success
    tick();
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1, 2'b01, 4'b0000, 0, 0, (k == 15));
      chk($sformatf("edge_mem%0d", k), obus, o(0,0,2'b00,1,0,1,0,2'b00,0,1,1,0));
      tick();
    end
    chk("edge_wb", obus, o(0,0,2'b00,0,0,0,1,2'b01,0,0,1,0));
    drive(1, 2'b01, 4'b0000, 0, 0, 1);
    tick();

    // run dropped in EXEC: the load still completes, then the core parks
    tick();
    tick();
    drive(0, 2'b01, 4'b0000, 0, 0, 1);
    chk("rundrop_exec", obus, o(0,0,2'b00,0,0,0,0,2'b00,0,1,1,0));
    tick();
    chk("rundrop_mem", obus, o(0,0,2'b00,1,0,1,0,2'b00,0,1,1,0));
    tick();
    chk("rundrop_wb", obus, o(0,0,2'b00,0,0,0,1,2'b01,0,0,1,0));
    tick();
    chk("rundrop_idle", obus, z0);

    // store that never completes trips the watchdog after 16 MEM cycles
    drive(1, 2'b10, 4'b0000, 0, 0, 1);
    tick();
    tick();
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1, 2'b10, 4'b0000, 0, 0, 0);
      chk($sformatf("to_mem%0d", k), obus, o(0,0,2'b00,0,1,1,0,2'b00,0,1,1,0));
      tick();
    end
    drive(1, 2'b00, 4'b0000, 0, 0, 0);
    chk("to_fetch_err", obus, o(0,0,2'b00,1,0,0,0,2'b00,0,0,1,1));
    drive(1, 2'b00, 4'b0000, 0, 0, 1);
    tick();
    tick();
    tick();
    drive(0, 2'b00, 4'b0000, 0, 0, 1);
    chk("err_sticky_wb", obus, o(0,0,2'b00,0,0,0,1,2'b00,0,0,1,1));
    tick();
    chk("err_sticky_idle", obus, o(0,0,2'b00,0,0,0,0,2'b00,0,0,0,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
